// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared constants and types for the push-button conditioner.
//   DEF_*         default divider / filter / auto-repeat settings
//   filt_state_t  per-channel filter state; bit [1] is the accepted level
//   max_int       small helper for sizing counters
// ---------------------------------------------------------------------------
package btn_pkg;

    localparam int DEF_TICK_DIV     = 3125000;  // 40 Hz sample tick at 125 MHz
    localparam int DEF_STABLE_N     = 2;
    localparam int DEF_REPEAT_DELAY = 20;
    localparam int DEF_REPEAT_RATE  = 4;

    // Encoding keeps the accepted level in bit [1] so the level output is a
    // direct flop bit with no decode.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        PEND_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        PEND_LOW  = 2'b11
    } filt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-FF synchroniser, consecutive-sample filter evaluated
// on the shared sample tick, registered press/release pulses.
// Optional auto-repeat when BTN_AUTOREPEAT_EN is defined.
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   i_tick       shared sample-tick strobe
//   i_btn        raw asynchronous button input (1 = pressed)
//   o_state      filter state (bit [1] = debounced level)
//   o_press      1-cycle pulse on accepted 0->1 (and auto-repeat)
//   o_release    1-cycle pulse on accepted 1->0
// ---------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_N     = DEF_STABLE_N,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_tick,
    input  logic        i_btn,
    output filt_state_t o_state,
    output logic        o_press,
    output logic        o_release
);

    localparam int RUN_W = $clog2(STABLE_N + 1);

    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [1:0]       r_sync;
    filt_state_t      r_state;
    logic [RUN_W-1:0] r_run;
    logic             r_press;
    logic             r_release;

    logic w_s;
    logic w_level;
    logic w_run_full;
    logic w_repeat;

    assign w_s        = r_sync[1];
    assign w_level    = r_state[1];
    assign w_run_full = (r_run == RUN_W'(STABLE_N - 1));

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_rep_phase;   // 0: waiting for first repeat, 1: periodic
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_held;

    // A tick that accepts a release does not count as held, so a repeat can
    // never coincide with the release pulse.
    assign w_held     = i_tick && w_level && !(!w_s && w_run_full);
    assign w_hold_nxt = r_hold + 1'b1;
    assign w_repeat   = w_held &&
                        (w_hold_nxt == (r_rep_phase ? HOLD_W'(REPEAT_RATE)
                                                    : HOLD_W'(REPEAT_DELAY)));

    // Counter reloads to 0 on each repeat, so it is bounded by the larger
    // interval and cannot wrap into a spurious repeat.
    always_ff @(posedge CLK) begin
        if (RST || !w_level) begin
            r_hold      <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_held) begin
            if (w_repeat) begin
                r_hold      <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_hold <= w_hold_nxt;
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync    <= 2'b00;
            r_state   <= IDLE_LOW;
            r_run     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_press   <= w_repeat;
            r_release <= 1'b0;
            if (i_tick) begin
                unique case (r_state)
                    IDLE_LOW, PEND_HIGH: begin
                        if (!w_s) begin
                            r_state <= IDLE_LOW;
                            r_run   <= '0;
                        end else if (w_run_full) begin
                            r_state <= IDLE_HIGH;
                            r_run   <= '0;
                            r_press <= 1'b1;
                        end else begin
                            r_state <= PEND_HIGH;
                            r_run   <= r_run + 1'b1;
                        end
                    end
                    IDLE_HIGH, PEND_LOW: begin
                        if (w_s) begin
                            r_state <= IDLE_HIGH;
                            r_run   <= '0;
                        end else if (w_run_full) begin
                            r_state   <= IDLE_LOW;
                            r_run     <= '0;
                            r_release <= 1'b1;
                        end else begin
                            r_state <= PEND_LOW;
                            r_run   <= r_run + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE_LOW;
                        r_run   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_debounce_array.sv
// ---------------------------------------------------------------------------
// btn_debounce_array
// N-channel push-button conditioner. Holds the shared sample-tick divider and
// one btn_debounce_ch per button.
// Optional feature: define BTN_AUTOREPEAT_EN for held-button auto-repeat.
// Ports:
//   CLK          system clock
//   RST          synchronous, active-high reset
//   BTNIN        raw asynchronous button inputs, 1 = pressed
//   BTN_LEVEL    debounced level
//   BTN_PRESS    1-cycle pulse on accepted 0->1 (and auto-repeat)
//   BTN_RELEASE  1-cycle pulse on accepted 1->0
//   TICK         sample-tick strobe, 1 cycle every TICK_DIV cycles
// ---------------------------------------------------------------------------
module btn_debounce_array
    import btn_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_N     = DEF_STABLE_N,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] BTNIN,
    output logic [NCH-1:0] BTN_LEVEL,
    output logic [NCH-1:0] BTN_PRESS,
    output logic [NCH-1:0] BTN_RELEASE,
    output logic           TICK
);

    localparam int CNT_W = $clog2(TICK_DIV);

    if (NCH < 1 || TICK_DIV < 2 || STABLE_N < 1) begin : g_bad_cfg
        $error("btn_debounce_array: need NCH>=1, TICK_DIV>=2, STABLE_N>=1");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    filt_state_t      w_state [NCH];

    assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST || w_tick) r_cnt <= '0;
        else               r_cnt <= r_cnt + 1'b1;
    end

    assign TICK = w_tick;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_N     (STABLE_N),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .i_tick    (w_tick),
            .i_btn     (BTNIN[g]),
            .o_state   (w_state[g]),
            .o_press   (BTN_PRESS[g]),
            .o_release (BTN_RELEASE[g])
        );
        assign BTN_LEVEL[g] = w_state[g][1];
    end

endmodule

// File: tb/tb_btn_debounce_array.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_array
// Bench for btn_debounce_array with TICK_DIV=4, STABLE_N=3, NCH=4,
// REPEAT_DELAY=5, REPEAT_RATE=2. A reference model built from the behavioural
// rules (sample window per channel, tick = cycle count modulo divider) gives
// the expected outputs every cycle; directed phases add scenario checks.
// ---------------------------------------------------------------------------
module tb_btn_debounce_array;

    localparam int NCH          = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_N     = 3;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;

    // ---------------- clock / reset ----------------
    logic           CLK = 1'b0;
    logic           RST;
    logic [NCH-1:0] BTNIN;
    logic [NCH-1:0] BTN_LEVEL;
    logic [NCH-1:0] BTN_PRESS;
    logic [NCH-1:0] BTN_RELEASE;
    logic           TICK;

    always #5 CLK = ~CLK;

    btn_debounce_array #(
        .NCH          (NCH),
        .TICK_DIV     (TICK_DIV),
        .STABLE_N     (STABLE_N),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTNIN       (BTNIN),
        .BTN_LEVEL   (BTN_LEVEL),
        .BTN_PRESS   (BTN_PRESS),
        .BTN_RELEASE (BTN_RELEASE),
        .TICK        (TICK)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NCH-1:0] e_level   = '0;
    logic [NCH-1:0] e_press   = '0;
    logic [NCH-1:0] e_release = '0;
    logic           e_tick    = 1'b0;
    bit             started   = 1'b0;

    int             m_cyc;             // clock edges since reset released
    logic [NCH-1:0] in_hist[$];        // inputs captured on the last two edges
    bit             samp[NCH][$];      // last STABLE_N tick samples per channel
    int             held[NCH];         // ticks spent at level 1 (auto-repeat)

    always @(posedge CLK) begin
        if (RST) begin
            started   = 1'b1;
            m_cyc     = 0;
            in_hist   = {};
            in_hist.push_back('0);
            in_hist.push_back('0);
            for (int c = 0; c < NCH; c++) begin
                samp[c] = {};
                held[c] = 0;
            end
            e_level   = '0;
            e_press   = '0;
            e_release = '0;
            e_tick    = 1'b0;
        end else if (started) begin
            logic [NCH-1:0] seen;
            bit             is_tick;
            is_tick   = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
            m_cyc++;
            seen      = in_hist.pop_front();
            in_hist.push_back(BTNIN);
            e_press   = '0;
            e_release = '0;
            if (is_tick) begin
                for (int c = 0; c < NCH; c++) begin
                    bit lvl;
                    bit flip;
                    lvl = e_level[c];
                    samp[c].push_back(seen[c]);
                    if (samp[c].size() > STABLE_N) void'(samp[c].pop_front());
                    // accept when the last STABLE_N samples all disagree with the level
                    flip = (samp[c].size() == STABLE_N);
                    for (int k = 0; k < samp[c].size(); k++)
                        if (samp[c][k] == lvl) flip = 1'b0;
                    if (flip) begin
                        e_level[c] = !lvl;
                        if (lvl) e_release[c] = 1'b1;
                        else     e_press[c]   = 1'b1;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    if (lvl && !flip) begin
                        held[c]++;
                        if (held[c] == REPEAT_DELAY ||
                            (held[c] > REPEAT_DELAY && ((held[c] - REPEAT_DELAY) % REPEAT_RATE) == 0))
                            e_press[c] = 1'b1;
                    end
`endif
                end
            end
            for (int c = 0; c < NCH; c++)
                if (!e_level[c]) held[c] = 0;
            e_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int press_cnt[NCH];
    int rel_cnt[NCH];
    bit saw_both;

    always @(negedge CLK) begin
        if (started) begin
            check_eq("level",   BTN_LEVEL,   e_level);
            check_eq("press",   BTN_PRESS,   e_press);
            check_eq("release", BTN_RELEASE, e_release);
            check_eq("tick",    TICK,        e_tick);
            check_eq("pr_excl", BTN_PRESS & BTN_RELEASE, '0);
            for (int c = 0; c < NCH; c++) begin
                if (BTN_PRESS[c])   press_cnt[c]++;
                if (BTN_RELEASE[c]) rel_cnt[c]++;
            end
            if (BTN_PRESS == 4'b1100) saw_both = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NCH; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
        end
        saw_both = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST   = 1'b1;
        BTNIN = '0;
        clear_counts();
        step(3);
        check_eq("rst_level", BTN_LEVEL, 0);
        check_eq("rst_tick",  TICK,      0);
        RST = 1'b0;

        // Clean press on ch0, held 40 cycles
        clear_counts();
        BTNIN[0] = 1'b1;
        step(40);
        check_eq("p1_level0", BTN_LEVEL[0], 1);
`ifndef BTN_AUTOREPEAT_EN
        check_eq("p1_press0", press_cnt[0], 1);
`endif
        check_eq("p1_others", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // Release ch0
        BTNIN[0] = 1'b0;
        step(30);
        check_eq("p2_rel0",   rel_cnt[0],   1);
        check_eq("p2_level0", BTN_LEVEL[0], 0);

        // Bounce on ch1: high for exactly two tick periods
        clear_counts();
        BTNIN[1] = 1'b1;
        step(2 * TICK_DIV);
        BTNIN[1] = 1'b0;
        step(30);
        check_eq("p3_press1", press_cnt[1], 0);
        check_eq("p3_level1", BTN_LEVEL[1], 0);

        // ch2 and ch3 pressed in the same cycle
        clear_counts();
        BTNIN[3:2] = 2'b11;
        step(30);
        check_eq("p4_both", saw_both, 1);
        BTNIN[3:2] = 2'b00;
        step(30);
        check_eq("p4_rel", rel_cnt[2] + rel_cnt[3], 2);

        // Reset after partial history on ch0
        clear_counts();
        BTNIN[0] = 1'b1;
        step(2 + 2 * TICK_DIV);
        RST = 1'b1;
        step(1);
        check_eq("p5_rst_level", BTN_LEVEL, 0);
        check_eq("p5_rst_press", BTN_PRESS, 0);
        RST = 1'b0;
        step(2 + 2 * TICK_DIV);
        check_eq("p5_early", BTN_LEVEL[0], 0);
        step(30);
        check_eq("p5_level0", BTN_LEVEL[0], 1);
        BTNIN[0] = 1'b0;
        step(30);

        // Randomized bouncing / holding with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 15) == 0) BTNIN[c] = ~BTNIN[c];
            RST = ($urandom_range(0, 599) == 0);
            step(1);
        end
        RST   = 1'b0;
        BTNIN = '0;
        step(40);
        check_eq("end_level", BTN_LEVEL, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
